// File: rtl/ram_pkg.sv
// Shared types and helpers for the synchronous data RAM and its controller.
package ram_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 15;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  // Even parity bit over a zero-extended word; zero padding leaves parity unchanged.
  function automatic logic parity_f(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Clocked storage: one write port, one registered read port with a synchronous clear.
module ram_array #(
  parameter int W     = 8,
  parameter int DEPTH = 32768,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rd_clr,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_q
);

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register; holds its value until the next read.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_q <= '0;
    end else if (re) begin
      rd_q <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ram_sync_ctrl.sv
// Synchronous single-port data RAM with hardware clear after reset and access checking.
// Optional parity storage/check is enabled by defining RAM_PARITY_EN.
module ram_sync_ctrl
  import ram_pkg::*;
#(
  parameter int                DATA_W  = RAM_DATA_W,
  parameter int                ADDR_W  = RAM_ADDR_W,
  parameter int                DEPTH   = 32768,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              acc_err,
  output logic              par_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  ram_state_t        state_r;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic              busy_r;
  logic              rd_valid_r;
  logic              acc_err_r;

  logic              in_range_s;
  logic              req_ok_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              err_s;
  logic              clearing_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_waddr_s;
  logic [DATA_W-1:0] wdata_sel_s;
  logic [MEM_W-1:0]  mem_wdata_s;
  logic [MEM_W-1:0]  rd_q_s;

  // One extra bit on the compare so DEPTH == 2**ADDR_W does not wrap.
  assign in_range_s = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign req_ok_s   = !reset && (state_r == IDLE) && sel;
  assign wr_acc_s   = req_ok_s && wr_en && !rd_en && in_range_s;
  assign rd_acc_s   = req_ok_s && rd_en && !wr_en && in_range_s;
  assign err_s      = req_ok_s && ((wr_en && rd_en) || ((wr_en || rd_en) && !in_range_s));
  assign clearing_s = !reset && (state_r == CLEAR);
  assign mem_we_s   = clearing_s || wr_acc_s;

  // Write-port source: clear sequencer or bus.
  always_comb begin
    mem_waddr_s = '0;
    wdata_sel_s = '0;
    if (clearing_s) begin
      mem_waddr_s = clr_ptr_r[IDX_W-1:0];
      wdata_sel_s = CLR_VAL;
    end else begin
      mem_waddr_s = addr[IDX_W-1:0];
      wdata_sel_s = wr_data;
    end
  end

`ifdef RAM_PARITY_EN
  assign mem_wdata_s = {parity_f(64'(wdata_sel_s)), wdata_sel_s};
  assign par_err     = rd_valid_r && (parity_f(64'(rd_q_s[DATA_W-1:0])) != rd_q_s[DATA_W]);
`else
  assign mem_wdata_s = wdata_sel_s;
  assign par_err     = 1'b0;
`endif

  ram_array #(
    .W     (MEM_W),
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_clr  (reset),
    .we      (mem_we_s),
    .wr_addr (mem_waddr_s),
    .wr_data (mem_wdata_s),
    .re      (rd_acc_s),
    .rd_addr (addr[IDX_W-1:0]),
    .rd_q    (rd_q_s)
  );

  // Controller FSM: clear sequence, then serve accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= CLEAR;
      clr_ptr_r  <= '0;
      busy_r     <= 1'b1;
      rd_valid_r <= 1'b0;
      acc_err_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
      acc_err_r  <= err_s;
      case (state_r)
        CLEAR: begin
          clr_ptr_r <= clr_ptr_r + ADDR_W'(1);
          if (clr_ptr_r == ADDR_W'(DEPTH - 1)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            busy_r  <= 1'b1;
          end
        end
        IDLE: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r   <= CLEAR;
          clr_ptr_r <= '0;
          busy_r    <= 1'b1;
        end
      endcase
    end
  end

  assign rd_data  = rd_q_s[DATA_W-1:0];
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;
  assign acc_err  = acc_err_r;

endmodule
